// File: rtl/hv_stream_unpack.sv
// Reassembles 512-bit stream beats into hypervectors and deals them
// round-robin to a bank of cores, one load strobe per vector.
module hv_stream_unpack #(
  parameter int DIM     = 1023,
  parameter int CORENUM = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               src_v,
  input  logic [511:0]       src_d,
  input  logic               src_last,
  output logic               src_ready,
  input  logic [CORENUM-1:0] core_ready,
  output logic [DIM:0]       core_hv,
  output logic [CORENUM-1:0] core_load,
  output logic               done,
  output logic [15:0]        vec_count,
  output logic               err
);

  localparam int BEATS = (DIM + 1) / 512;
  localparam int KW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PW = (CORENUM > 1) ? $clog2(CORENUM) : 1;

  localparam logic [KW-1:0] K_LAST = KW'(BEATS - 1);
  localparam logic [PW-1:0] P_LAST = PW'(CORENUM - 1);

  localparam logic [1:0] FILL     = 2'd0;
  localparam logic [1:0] DISPATCH = 2'd1;
  localparam logic [1:0] DONE     = 2'd2;

  logic [1:0]    state;
  logic [KW-1:0] k;
  logic [PW-1:0] ptr;
  logic          last_q;
  logic          accept;
  logic          last_beat;
  logic          fire;

  // Outputs are forced quiet while reset is held low.
  assign src_ready = rst && (state == FILL);
  assign accept    = src_v && src_ready;
  assign last_beat = accept && (k == K_LAST);
  assign done      = (state == DONE);

  always_comb begin
    core_load = '0;
    if (rst && (state == DISPATCH) && core_ready[ptr]) begin
      core_load[ptr] = 1'b1;
    end
  end

  assign fire = |core_load;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= FILL;
    end else begin
      case (state)
        FILL: begin
          if (last_beat) state <= DISPATCH;
        end
        DISPATCH: begin
          if (fire) state <= last_q ? DONE : FILL;
        end
        DONE:    state <= FILL;
        default: state <= FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k      <= '0;
      last_q <= 1'b0;
      err    <= 1'b0;
    end else begin
      if (accept) begin
        k <= (k == K_LAST) ? '0 : k + KW'(1);
      end
      if (last_beat) begin
        last_q <= src_last;
      end else if (state == DONE) begin
        last_q <= 1'b0;
      end
      // A job end flagged mid-vector is a framing error; it stays
      // visible until reset so software can spot it after the job.
      if (accept && src_last && (k != K_LAST)) begin
        err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr       <= '0;
      vec_count <= '0;
    end else if (state == DONE) begin
      ptr       <= '0;
      vec_count <= '0;
    end else if (fire) begin
      ptr       <= (ptr == P_LAST) ? '0 : ptr + PW'(1);
      vec_count <= vec_count + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_hv <= '0;
    end else if (accept) begin
      for (int b = 0; b < BEATS; b++) begin
        if (k == KW'(b)) core_hv[512*b +: 512] <= src_d;
      end
    end
  end

endmodule

// File: tb/tb_hv_stream_unpack.sv
// Bench for hv_stream_unpack: vector-level scoreboard plus directed
// literal checks on latency, stalls, framing errors and reset.
module tb_hv_stream_unpack;

  localparam int DIM = 1023;
  localparam int NC  = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           src_v;
  logic [511:0]   src_d;
  logic           src_last;
  logic           src_ready;
  logic [NC-1:0]  core_ready;
  logic [DIM:0]   core_hv;
  logic [NC-1:0]  core_load;
  logic           done;
  logic [15:0]    vec_count;
  logic           err;

  hv_stream_unpack #(.DIM(DIM), .CORENUM(NC)) dut (
    .clk       (clk),
    .rst       (rst_n),
    .src_v     (src_v),
    .src_d     (src_d),
    .src_last  (src_last),
    .src_ready (src_ready),
    .core_ready(core_ready),
    .core_hv   (core_hv),
    .core_load (core_load),
    .done      (done),
    .vec_count (vec_count),
    .err       (err)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  // Scoreboard: whole vectors in dispatch order, with their job-end flag.
  logic [DIM:0] exp_q[$];
  bit           exp_lastq[$];
  int           exp_core;
  logic [15:0]  exp_count;
  bit           pend_done;
  int           done_seen;
  logic [7:0]   el;

  logic [511:0] va = {128{4'h1}};
  logic [511:0] vb = {128{4'h2}};
  logic [511:0] vc = {128{4'h3}};
  logic [511:0] vd = {128{4'h4}};

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    nchk++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_hv(input string name, input logic [DIM:0] act,
                          input logic [DIM:0] req);
    int w;
    w = -1;
    nchk++;
    if (act !== req) begin
      nerr++;
      for (int i = 0; i < (DIM + 1) / 64; i++) begin
        if (w < 0 && act[i*64 +: 64] !== req[i*64 +: 64]) w = i;
      end
      $display("FAIL %s: word %0d got %0h want %0h at %0t", name, w,
               act[w*64 +: 64], req[w*64 +: 64], $time);
    end
  endtask

  function automatic logic [511:0] rnd();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Entered and left at posedge+1.
  task automatic send_beat(input logic [511:0] d, input bit l,
                           input int idle, output bit ok);
    src_v = 1'b0;
    repeat (idle) begin
      @(posedge clk);
      #1;
    end
    src_v    = 1'b1;
    src_d    = d;
    src_last = l;
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (src_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    src_v    = 1'b0;
    src_last = 1'b0;
    src_d    = rnd();
    check("beat_accept", 64'(ok), 64'd1);
  endtask

  task automatic send_vec(input logic [511:0] a, input logic [511:0] b,
                          input bit la, input bit lb, input int idle);
    bit ok1;
    bit ok2;
    send_beat(a, la, idle, ok1);
    send_beat(b, lb, idle, ok2);
    if (ok1 && ok2) begin
      exp_q.push_back({b, a});
      exp_lastq.push_back(lb);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_src_ready", 64'(src_ready), 64'd0);
      check("rst_core_load", 64'(core_load), 64'd0);
    end else if (pend_done) begin
      check("done_pulse", 64'(done), 64'd1);
      check("done_src_ready", 64'(src_ready), 64'd0);
      check("done_core_load", 64'(core_load), 64'd0);
      check("done_vec_count", 64'(vec_count), 64'(exp_count));
      pend_done = 1'b0;
      exp_count = '0;
      exp_core  = 0;
      done_seen++;
    end else begin
      check("no_done", 64'(done), 64'd0);
      check("vec_count", 64'(vec_count), 64'(exp_count));
      if (exp_q.size() > 0) begin
        el = core_ready[exp_core] ? (8'h01 << exp_core) : 8'h00;
        check("core_load", 64'(core_load), 64'(el));
        check("disp_src_ready", 64'(src_ready), 64'd0);
        check_hv("core_hv", core_hv, exp_q[0]);
        if (el != 8'h00) begin
          pend_done = exp_lastq[0];
          void'(exp_q.pop_front());
          void'(exp_lastq.pop_front());
          exp_count = exp_count + 16'd1;
          exp_core  = (exp_core + 1) % NC;
        end
      end else begin
        check("idle_core_load", 64'(core_load), 64'd0);
        check("fill_src_ready", 64'(src_ready), 64'd1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int d0;
    bit ok;
    rst_n      = 1'b0;
    src_v      = 1'b0;
    src_d      = '0;
    src_last   = 1'b0;
    core_ready = 8'hFF;
    exp_core   = 0;
    exp_count  = '0;
    pend_done  = 1'b0;
    done_seen  = 0;
    #1;
    check("reset_ready", 64'(src_ready), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_err", 64'(err), 64'd0);
    check("reset_count", 64'(vec_count), 64'd0);
    check_hv("reset_hv", core_hv, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 64'(src_ready), 64'd1);
    @(posedge clk);
    #1;

    // Two-beat job with literal latency expectations.
    send_vec(va, vb, 1'b0, 1'b1, 0);
    @(negedge clk);
    check("t1_load", 64'(core_load), 64'h01);
    check_hv("t1_hv", core_hv, {vb, va});
    check("t1_cnt0", 64'(vec_count), 64'd0);
    @(negedge clk);
    check("t1_done", 64'(done), 64'd1);
    check("t1_cnt1", 64'(vec_count), 64'd1);
    @(negedge clk);
    check("t1_after_done", 64'(done), 64'd0);
    check("t1_cnt_clr", 64'(vec_count), 64'd0);
    check("t1_ready", 64'(src_ready), 64'd1);
    @(posedge clk);
    #1;

    // Nine vectors: pointer wraps back to core 0.
    d0 = done_seen;
    for (int v = 0; v < 9; v++) send_vec(rnd(), rnd(), 1'b0, v == 8, 0);
    @(negedge clk);
    check("t2_wrap_load", 64'(core_load), 64'h01);
    @(negedge clk);
    check("t2_done", 64'(done), 64'd1);
    check("t2_cnt9", 64'(vec_count), 64'd9);
    @(posedge clk);
    #1;
    check("t2_one_done", 64'(done_seen - d0), 64'd1);

    // Core 0 not ready for five cycles.
    core_ready = 8'hFE;
    send_vec(rnd(), rnd(), 1'b0, 1'b1, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_stall_load", 64'(core_load), 64'd0);
      check("t3_stall_ready", 64'(src_ready), 64'd0);
    end
    @(posedge clk);
    #1 core_ready = 8'hFF;
    @(negedge clk);
    check("t3_load_core0", 64'(core_load), 64'h01);
    @(negedge clk);
    check("t3_done", 64'(done), 64'd1);
    @(posedge clk);
    #1;

    // Job end flagged on beat 0: framing error, no done.
    send_vec(rnd(), rnd(), 1'b1, 1'b0, 0);
    @(negedge clk);
    check("t4_err", 64'(err), 64'd1);
    @(posedge clk);
    #1;
    send_vec(rnd(), rnd(), 1'b0, 1'b1, 1);
    repeat (3) @(negedge clk);
    check("t4_err_sticky", 64'(err), 64'd1);
    @(posedge clk);
    #1;

    // Reset after beat 0: partial vector discarded, asynchronously.
    send_beat(rnd(), 1'b0, 0, ok);
    rst_n = 1'b0;
    #1;
    check("t5_rst_ready", 64'(src_ready), 64'd0);
    check("t5_rst_load", 64'(core_load), 64'd0);
    check("t5_rst_err", 64'(err), 64'd0);
    check_hv("t5_rst_hv", core_hv, '0);
    exp_q.delete();
    exp_lastq.delete();
    exp_core  = 0;
    exp_count = '0;
    pend_done = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("t5_ready", 64'(src_ready), 64'd1);
    @(posedge clk);
    #1;
    send_vec(vc, vd, 1'b0, 1'b1, 0);
    @(negedge clk);
    check("t5_load", 64'(core_load), 64'h01);
    check_hv("t5_hv", core_hv, {vd, vc});
    @(negedge clk);
    check("t5_done", 64'(done), 64'd1);
    @(posedge clk);
    #1;

    // Gappy source, all cores ready.
    for (int v = 0; v < 12; v++) begin
      send_vec(rnd(), rnd(), 1'b0, v == 11, $urandom_range(0, 2));
    end
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
    check("drain_queue", 64'(exp_q.size()), 64'd0);
    check("drain_done", 64'(pend_done), 64'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/hv_stream_unpack.md
HV_STREAM_UNPACK -- requirements
Module: hv_stream_unpack

Interface
REQ-001 SHALL have parameter DIM, default 1023, meaning hypervector MSB index; vector width is DIM+1, which SHALL be a multiple of 512.
REQ-002 SHALL have parameter CORENUM, default 8, meaning the number of cores fed.
REQ-003 SHALL define BEATS = (DIM+1)/512, the number of stream words per vector (2 at default).
REQ-004 SHALL have one clock and an asynchronous, active-low reset, with ports named as follows.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 src_v  in  1  input stream word valid.
REQ-008 src_d  in  512  input stream word.
REQ-009 src_last  in  1  marks the final word of the final vector in a job.
REQ-010 src_ready  out  1  block accepts src_d this cycle.
REQ-011 core_ready  in  CORENUM  per-core ready to take a vector.
REQ-012 core_hv  out  DIM+1  assembled hypervector broadcast to all cores.
REQ-013 core_load  out  CORENUM  one-hot, one-cycle load strobe per dispatched vector.
REQ-014 done  out  1  one-cycle pulse after the final vector of a job is dispatched.
REQ-015 vec_count  out  16  vectors dispatched in the current job.
REQ-016 err  out  1  sticky protocol-error flag.

Function
REQ-017 SHALL use FSM states FILL, DISPATCH and DONE; reset state is FILL.
REQ-018 A beat SHALL be accepted when src_v and src_ready are both 1.
REQ-019 src_ready SHALL be 1 only in FILL.
REQ-020 Beat index k (0..BEATS-1) SHALL write src_d into core_hv[512k+511:512k].
REQ-021 k SHALL increment per accepted beat and wrap to 0 after BEATS-1.
REQ-022 Accepting beat BEATS-1 SHALL move the FSM to DISPATCH on the next cycle and latch src_last into last_q.
REQ-023 src_last on a beat with k != BEATS-1 SHALL set err and be otherwise ignored.
REQ-024 err SHALL clear only on reset.
REQ-025 In DISPATCH, a round-robin pointer ptr (0..CORENUM-1) selects the target core; vectors are issued strictly in order and no core is skipped.
REQ-026 core_load SHALL be combinational: bit ptr = 1 exactly when state is DISPATCH and core_ready[ptr] = 1; all other bits 0.
REQ-027 While core_ready[ptr] = 0, the FSM SHALL stay in DISPATCH with core_load = 0, core_hv stable and src_ready = 0.
REQ-028 In a cycle where core_load is nonzero, the block SHALL increment ptr modulo CORENUM and increment vec_count (wrapping at 2^16).
REQ-029 In that same load cycle, the FSM SHALL go to DONE if last_q = 1, otherwise to FILL.
REQ-030 DONE SHALL last exactly one cycle with done = 1, then go to FILL.
REQ-031 On leaving DONE, ptr, vec_count and last_q SHALL reset to 0 at the DONE-to-FILL transition.
REQ-032 core_hv SHALL hold its value outside beat-write cycles.
REQ-033 core_hv SHALL be stable from DISPATCH entry until the load cycle.
REQ-034 Latency: with core_ready all 1, the last beat accepted at cycle N gives core_load at cycle N+1 and done (if last) at N+2.
REQ-035 Sustained throughput SHALL be one vector per BEATS+1 cycles.
REQ-036 src_v without acceptance (FILL not active) SHALL have no effect; the source holds data.

Reset
REQ-037 rst low SHALL immediately clear state to FILL and clear k, ptr, last_q, vec_count, err, done and core_hv.
REQ-038 While rst is low, src_ready and core_load SHALL be 0.
REQ-039 src_ready SHALL be 1 in the first cycle after rst rises.
REQ-040 Reset mid-vector or mid-DISPATCH SHALL discard the partial vector and emit no core_load.

Verification
REQ-041 Two beats A=512'h1…, B=512'h2…, src_last on B, core_ready=all 1 -> core_hv={B,A}, core_load=8'h01 one cycle later, done the cycle after, vec_count=1 then 0.
REQ-042 Nine vectors, last on 9th, all ready -> core_load sequence 01,02,04,…,80,01; vec_count reaches 9; one done pulse.
REQ-043 core_ready=8'hFE during vector 0 dispatch for 5 cycles -> src_ready=0 and core_load=0 for 5 cycles; load to core 0 when bit 0 rises; no skip to core 1.
REQ-044 src_last on beat 0 -> err=1 and stays 1; beat 1 still completes the vector; no done unless src_last on beat 1.
REQ-045 rst low after beat 0 of a vector -> after release src_ready=1, k=0, the next two beats form a fresh vector, no stale bits.
REQ-046 src_v toggling randomly with all cores ready -> each core_hv matches the beat pairs in order; no beat lost or duplicated.
